// File: rtl/aes.sv
// AES-128 encryption core: fully unrolled, one block per clock, no handshake.
// Stage 0 registers text^key; stages 1..9 each register one full round with
// its own round key. Round 10 (no MixColumns) is combinational off stage 9.
// Optional macro AES_OUTPUT_REG_EN registers round 10 into otext (+1 latency).
module aes (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] text,
  input  logic [127:0] key,
  output logic [127:0] otext
);

  // Byte b of the S-box lives at bits [2047-8b -: 8].
  localparam logic [2047:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Rcon[i] at bits [8*(10-i) +: 8].
  localparam logic [79:0] RconTbl = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTbl[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int n = 0; n < 16; n++) o[8*n +: 8] = sbox(s[8*n +: 8]);
    return o;
  endfunction

  // Byte n = 4c + r; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] st_q [10];
  logic [127:0] k_q  [10];
  logic [127:0] rk_d [1:10];
  logic [127:0] rnd_d [1:9];
  logic [127:0] last_d;

  // Round keys and round results for every stage, derived from the previous stage.
  always_comb begin
    for (int i = 1; i <= 10; i++) rk_d[i] = key_exp(k_q[i-1], RconTbl[8*(10-i) +: 8]);
    for (int i = 1; i <= 9; i++) begin
      rnd_d[i] = mix_columns(shift_rows(sub_bytes(st_q[i-1]))) ^ rk_d[i];
    end
    last_d = shift_rows(sub_bytes(st_q[9])) ^ rk_d[10];
  end

  // Pipeline registers: state and round key advance together every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 10; i++) begin
        st_q[i] <= '0;
        k_q[i]  <= '0;
      end
    end else begin
      st_q[0] <= text ^ key;
      k_q[0]  <= key;
      for (int i = 1; i < 10; i++) begin
        st_q[i] <= rnd_d[i];
        k_q[i]  <= rk_d[i];
      end
    end
  end

`ifdef AES_OUTPUT_REG_EN
  logic [127:0] otext_q;

  // Registered final round.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) otext_q <= '0;
    else      otext_q <= last_d;
  end

  assign otext = otext_q;
`else
  assign otext = last_d;
`endif

endmodule

// File: tb/tb_aes.sv
// Self-checking bench for aes: random blocks against a byte-level AES-128 model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes;

`ifdef AES_OUTPUT_REG_EN
  localparam int Lat = 11;
  localparam logic [127:0] RstOut = 128'h0;
`else
  localparam int Lat = 10;
  // Round 10 of all-zero state/key: SubBytes gives 63s, k10 words are 55636363.
  localparam logic [127:0] RstOut = 128'h36000000360000003600000036000000;
`endif

  logic         clk;
  logic         rst;
  logic [127:0] text;
  logic [127:0] key;
  logic [127:0] otext;

  aes dut (
    .clk  (clk),
    .rst  (rst),
    .text (text),
    .key  (key),
    .otext(otext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int edges;
  int last_low;
  logic [7:0]   sb   [256];
  logic [127:0] hist [int];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n%4][n/4] = pt[127-8*n -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                      ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n%4][n/4];
    return o;
  endfunction

  // One rising edge; checks the block sampled Lat-1 edges earlier if still valid.
  task automatic step();
    int n;
    @(posedge clk);
    edges++;
    if (!rst) last_low = edges;
    #1;
    n = edges - (Lat - 1);
    if (n > last_low && hist.exists(n)) check($sformatf("ct@%0d", n), otext, hist[n]);
  endtask

  task automatic drive(input logic [127:0] t, input logic [127:0] k, input logic [127:0] exp);
    text = t;
    key  = k;
    hist[edges+1] = exp;
  endtask

  task automatic drive_rand();
    logic [127:0] t, k;
    t = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    drive(t, k, ref_enc(t, k));
  endtask

  initial begin
    logic [7:0] inv;
    total    = 0;
    bad      = 0;
    edges    = 0;
    last_low = 0;
    rst      = 1'b0;
    text     = '0;
    key      = '0;

    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    #2;
    check("reset_init", otext, RstOut);
    step();
    step();
    check("reset_hold", otext, RstOut);
    rst = 1'b1;

    // Known-answer vectors back-to-back, then random traffic.
    drive(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
          128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    step();
    drive(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
          128'h3925841d02dc09fbdc118597196a0b32);
    step();
    drive(128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    step();
    for (int i = 0; i < 40; i++) begin
      drive_rand();
      step();
    end

    // Asynchronous reset with the pipeline full.
    #2;
    rst      = 1'b0;
    last_low = edges;
    #1;
    check("reset_async", otext, RstOut);
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      step();
      check($sformatf("reset_low%0d", i), otext, RstOut);
    end
    rst = 1'b1;

    for (int i = 0; i < 30 + Lat; i++) begin
      drive_rand();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
